axi_stream_remove_header: RTL



---
 rtl/axi_stream_pkg.sv | 34 +++
 rtl/axi_stream_out_reg.sv | 40 ++++
 rtl/axi_stream_remove_header.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream header insert/remove stages:
// FSM state encoding and keep-vector helpers.
package axi_stream_pkg;

    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        BODY,
        TAIL
    } state_t;

    // Number of set bits in a keep vector (keep is contiguous from its MSB).
    function automatic int keep_to_cnt(input logic [MAX_BYTES-1:0] keep);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

    // n ones aligned to the top of a width-bit field, zeros elsewhere.
    function automatic logic [MAX_BYTES-1:0] msb_mask(input int n, input int width);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < width) && (i >= width - n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_stream_out_reg.sv
// Single output register stage for an AXI-Stream source; holds its beat
// while the consumer stalls and reports when a new beat may be loaded.
module axi_stream_out_reg #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DATA_WD-1:0]      load_data,
    input  logic [DATA_BYTE_WD-1:0] load_keep,
    input  logic                    load_last,
    input  logic                    ready_out,
    output logic                    slot_free,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out
);

    assign slot_free = !valid_out || ready_out;

    // load is only raised by the owner while slot_free is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= load_data;
            keep_out  <= load_keep;
            last_out  <= load_last;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips R leading bytes from each AXI-Stream packet and re-packs the rest
// so that every output beat except the last carries a full keep.
module axi_stream_remove_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove
);

    localparam int CNT_W = BYTE_CNT_WD + 1;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        strip_cnt;
    logic [CNT_W-1:0]        res_cnt;
    logic [DATA_WD-1:0]      residue;

    logic                    slot_free;
    logic                    load;
    logic [DATA_WD-1:0]      load_data;
    logic [DATA_BYTE_WD-1:0] load_keep;
    logic                    load_last;

    logic [DATA_WD-1:0]      data_m;
    logic [DATA_WD-1:0]      shl_data;
    logic [DATA_WD-1:0]      hi_data;
    logic [DATA_BYTE_WD-1:0] hi_keep;
    logic [CNT_W-1:0]        nb_in;
    logic [CNT_W-1:0]        rc_new;
    logic [DATA_BYTE_WD-1:0] new_keep;
    logic [DATA_BYTE_WD-1:0] res_keep;
    logic                    beat_acc;

    // Lanes outside keep are forced to zero so they never leak into output.
    always_comb begin
        data_m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            data_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
        end
    end

    // Constant-shift alternatives selected by the latched strip count.
    always_comb begin
        shl_data = '0;
        hi_data  = '0;
        hi_keep  = '0;
        for (int k = 1; k <= DATA_BYTE_WD; k++) begin
            if (strip_cnt == CNT_W'(k)) begin
                shl_data = data_m << (8 * k);
                hi_data  = data_m >> (8 * (DATA_BYTE_WD - k));
                hi_keep  = keep_in >> (DATA_BYTE_WD - k);
            end
        end
    end

    assign nb_in    = CNT_W'(keep_to_cnt(MAX_BYTES'(keep_in)));
    assign rc_new   = (nb_in > strip_cnt) ? (nb_in - strip_cnt) : '0;
    assign new_keep = DATA_BYTE_WD'(msb_mask(int'(rc_new), DATA_BYTE_WD));
    assign res_keep = DATA_BYTE_WD'(msb_mask(int'(res_cnt), DATA_BYTE_WD));
    assign beat_acc = valid_in && ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ready_in     = 1'b0;
        ready_remove = 1'b0;
        load         = 1'b0;
        load_data    = '0;
        load_keep    = '0;
        load_last    = 1'b0;
        unique case (state)
            IDLE: begin
                ready_remove = 1'b1;
                if (valid_remove) state_next = FIRST;
            end
            FIRST: begin
                ready_in = slot_free;
                if (valid_in && slot_free) begin
                    if (last_in) begin
                        state_next = IDLE;
                        if (rc_new != '0) begin
                            load      = 1'b1;
                            load_data = shl_data;
                            load_keep = new_keep;
                            load_last = 1'b1;
                        end
                    end else begin
                        state_next = BODY;
                    end
                end
            end
            BODY: begin
                ready_in = slot_free;
                if (valid_in && slot_free) begin
                    load      = 1'b1;
                    load_data = residue | hi_data;
                    load_keep = res_keep | hi_keep;
                    if (last_in) begin
                        if (nb_in <= strip_cnt) begin
                            load_last  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = residue;
                    load_keep  = res_keep;
                    load_last  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strip_cnt <= '0;
            res_cnt   <= '0;
            residue   <= '0;
        end else begin
            if (valid_remove && ready_remove) begin
                strip_cnt <= CNT_W'(byte_remove_cnt) + CNT_W'(1);
            end
            if (beat_acc) begin
                residue <= shl_data;
                res_cnt <= rc_new;
            end
        end
    end

    axi_stream_out_reg #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .ready_out (ready_out),
        .slot_free (slot_free),
        .valid_out (valid_out),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out)
    );

endmodule
